des3_sequencer: RTL and testbench

DES3_SEQUENCER -- requirements
Module: des3_sequencer

---
 rtl/des3_pkg.sv | 108 ++++++++++
 rtl/des_round.sv | 33 +++
 rtl/des3_sequencer.sv | 143 ++++++++++++++
 tb/tb_des3_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des3_pkg.sv
// Shared constants for the iterative Triple-DES sequencer: DES permutation
// tables, S-boxes, key rotation schedules, FSM states and the permutation
// helpers. Bit numbering follows DES: bit 1 is the MSB of each vector.
package des3_pkg;

  localparam int PASSES = 3;
  localparam int ROUNDS = 16;
  localparam logic [1:0] LAST_PASS  = 2'(PASSES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Each S-box is 64 nibbles in row-major order (row*16 + col); entry 0 is
  // the most significant nibble of the literal.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Encrypt passes rotate C/D left before PC-2; decrypt passes rotate right
  // so the subkeys come out K16..K1.
  localparam int SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SHIFT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] ip_perm(input logic [63:0] v);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = v[64-IP_TBL[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] v);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = v[64-FP_TBL[i]];
    return o;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] v);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = v[32-E_TBL[i]];
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] v);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[31-i] = v[32-P_TBL[i]];
    return o;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] v);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = v[64-PC1_TBL[i]];
    return o;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] v);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = v[56-PC2_TBL[i]];
    return o;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int s);
    return (v << s) | (v >> (28 - s));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input int s);
    return (v >> s) | (v << (28 - s));
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L xor f(R, subkey).
module des_round
  import des3_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [47:0] subkey_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o
);

  logic [47:0] mixed;
  logic [31:0] sbox_out;

  // Expand, key-mix and substitute R through the eight S-boxes.
  always_comb begin
    logic [5:0] six;
    int         idx;
    // NOTE: every combinational output gets a value before any branch or
    // loop touches it, so no path can leave it holding its old value (latch).
    sbox_out = '0;
    mixed    = e_expand(r_i) ^ subkey_i;
    for (int j = 0; j < 8; j++) begin
      six = mixed[47-6*j -: 6];
      idx = int'({six[5], six[0], six[4:1]});
      sbox_out[31-4*j -: 4] = SBOX[j][255-4*idx -: 4];
    end
  end

  assign l_o = r_i;
  assign r_o = l_i ^ p_perm(sbox_out);

endmodule

// File: rtl/des3_sequencer.sv
// Iterative Triple-DES (EDE / DED) engine: one Feistel round per cycle,
// 48 rounds per block, single shared round, ready/valid handshake on both sides.
module des3_sequencer
  import des3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [63:0] in_data,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [63:0] key1_q, key1_d, key2_q, key2_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [1:0]  pass_q, pass_d;
  logic [3:0]  round_q, round_d;
  logic [63:0] out_q, out_d;

  logic        dec_pass;
  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] l_rnd, r_rnd;

  // Derive this round's subkey; the middle pass runs opposite to the outer two.
  always_comb begin
    dec_pass = mode_q ^ (pass_q == 2'd1);
    if (dec_pass) begin
      c_rot = rotr28(c_q, SHIFT_DEC[round_q]);
      d_rot = rotr28(d_q, SHIFT_DEC[round_q]);
    end else begin
      c_rot = rotl28(c_q, SHIFT_ENC[round_q]);
      d_rot = rotl28(d_q, SHIFT_ENC[round_q]);
    end
    subkey = pc2_perm({c_rot, d_rot});
  end

  des_round u_round (
    .l_i      (l_q),
    .r_i      (r_q),
    .subkey_i (subkey),
    .l_o      (l_rnd),
    .r_o      (r_rnd)
  );

  // Next-state logic: accept, iterate rounds, chain passes, hold result.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    key1_d  = key1_q;
    key2_d  = key2_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    pass_d  = pass_q;
    round_d = round_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_RUN;
          mode_d     = mode;
          key1_d     = key1;
          key2_d     = key2;
          {l_d, r_d} = ip_perm(in_data);
          {c_d, d_d} = pc1_perm(key1);
          pass_d     = '0;
          round_d    = '0;
        end
      end
      ST_RUN: begin
        l_d     = l_rnd;
        r_d     = r_rnd;
        c_d     = c_rot;
        d_d     = d_rot;
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          if (pass_q == LAST_PASS) begin
            out_d   = fp_perm({r_rnd, l_rnd});
            state_d = ST_DONE;
          end else begin
            // FP then IP cancel, so the swapped preoutput feeds the next pass.
            l_d        = r_rnd;
            r_d        = l_rnd;
            {c_d, d_d} = pc1_perm((pass_q == 2'd0) ? key2_q : key1_q);
            pass_d     = pass_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including keys.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      key1_q  <= '0;
      key2_q  <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      pass_q  <= '0;
      round_q <= '0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking updates make every register sample the values
      // from before the edge, independent of statement order.
      state_q <= state_d;
      mode_q  <= mode_d;
      key1_q  <= key1_d;
      key2_q  <= key2_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      pass_q  <= pass_d;
      round_q <= round_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_des3_sequencer.sv
// Self-checking bench for des3_sequencer against a behavioural Triple-DES model.
module tb_des3_sequencer;
  import des3_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [63:0] in_data, key1, key2, out_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] RT_K1   = 64'h0123456789ABCDEF;
  localparam logic [63:0] RT_K2   = 64'hFEDCBA9876543210;

  des3_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in_data   (in_data),
    .key1      (key1),
    .key2      (key2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Single DES: precompute K1..K16 by cumulative left rotations, then apply
  // them forwards (encrypt) or backwards (decrypt).
  function automatic logic [63:0] m_des(input logic [63:0] key, input logic [63:0] blk,
                                        input bit decrypt);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk [16];
    logic [47:0] x;
    logic [63:0] b, o;
    logic [31:0] l, r, t, f, s_out;
    logic [5:0]  six;
    int          sh, idx;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_TBL[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      c  = (c << sh) | (c >> (28 - sh));
      d  = (d << sh) | (d >> (28 - sh));
      cd = {c, d};
      for (int j = 0; j < 48; j++) sk[i][47-j] = cd[56-PC2_TBL[j]];
    end
    for (int i = 0; i < 64; i++) b[63-i] = blk[64-IP_TBL[i]];
    l = b[63:32];
    r = b[31:0];
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 48; j++) x[47-j] = r[32-E_TBL[j]];
      x = x ^ (decrypt ? sk[15-i] : sk[i]);
      for (int j = 0; j < 8; j++) begin
        six = x[47-6*j -: 6];
        idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
        s_out[31-4*j -: 4] = SBOX[j][255-4*idx -: 4];
      end
      for (int j = 0; j < 32; j++) f[31-j] = s_out[32-P_TBL[j]];
      t = r;
      r = l ^ f;
      l = t;
    end
    b = {r, l};
    for (int i = 0; i < 64; i++) o[63-i] = b[64-FP_TBL[i]];
    return o;
  endfunction

  function automatic logic [63:0] m_tdes(input bit m, input logic [63:0] k1, k2, blk);
    return m_des(k1, m_des(k2, m_des(k1, blk, m), !m), m);
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Submit one request, scramble the inputs while it runs (with stray
  // in_valid/out_ready pulses) and wait for the result; leaves it in DONE.
  task automatic run_op(input logic m, input logic [63:0] k1, k2, din,
                        output logic [63:0] dout, output int lat, output bit tmo);
    int n = 0;
    tmo  = 1'b0;
    lat  = 0;
    dout = '0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      tmo = 1'b1;
      return;
    end
    mode = m; key1 = k1; key2 = k2; in_data = din; in_valid = 1'b1;
    step();
    while (!out_valid && lat < 200) begin
      mode      = $urandom_range(0, 1);
      key1      = rnd64();
      key2      = rnd64();
      in_data   = rnd64();
      in_valid  = $urandom_range(0, 1);
      out_ready = (lat < 3);
      step();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tmo       = !out_valid;
    dout      = out_data;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    in_data = '0; key1 = '0; key2 = '0;
    repeat (3) step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_kat_encrypt();
    logic [63:0] res;
    int lat;
    bit tmo;
    run_op(1'b0, KAT_KEY, KAT_KEY, KAT_PT, res, lat, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL kat_enc_timeout: got %b want 0", tmo); end
    n_checks++; if (lat !== 48) begin n_fail++; $display("FAIL kat_enc_latency: got %0d want 48", lat); end
    n_checks++; if (res !== KAT_CT) begin n_fail++; $display("FAIL kat_enc_data: got %h want %h", res, KAT_CT); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kat_enc_busy_done: got %b want 1", busy); end
    release_result();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kat_enc_release_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kat_enc_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_kat_decrypt();
    logic [63:0] res;
    int lat;
    bit tmo;
    run_op(1'b1, KAT_KEY, KAT_KEY, KAT_CT, res, lat, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL kat_dec_timeout: got %b want 0", tmo); end
    n_checks++; if (lat !== 48) begin n_fail++; $display("FAIL kat_dec_latency: got %0d want 48", lat); end
    n_checks++; if (res !== KAT_PT) begin n_fail++; $display("FAIL kat_dec_data: got %h want %h", res, KAT_PT); end
    release_result();
  endtask

  task automatic test_round_trip();
    logic [63:0] blk, ct, pt, exp_ct;
    int lat;
    bit tmo;
    for (int i = 0; i < 16; i++) begin
      blk    = rnd64();
      exp_ct = m_tdes(1'b0, RT_K1, RT_K2, blk);
      run_op(1'b0, RT_K1, RT_K2, blk, ct, lat, tmo);
      release_result();
      n_checks++; if (ct !== exp_ct) begin n_fail++; $display("FAIL rt_enc[%0d]: got %h want %h", i, ct, exp_ct); end
      run_op(1'b1, RT_K1, RT_K2, ct, pt, lat, tmo);
      release_result();
      n_checks++; if (pt !== blk) begin n_fail++; $display("FAIL rt_dec[%0d]: got %h want %h", i, pt, blk); end
    end
  endtask

  task automatic test_done_hold();
    logic [63:0] k, blk, exp_res, nxt, res;
    int lat;
    bit tmo;
    k       = rnd64();
    blk     = rnd64();
    exp_res = m_tdes(1'b1, k, k ^ 64'hFFFF, blk);
    run_op(1'b1, k, k ^ 64'hFFFF, blk, res, lat, tmo);
    n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL hold_first: got %h want %h", res, exp_res); end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; mode = $urandom_range(0, 1);
      in_data = rnd64(); key1 = rnd64(); key2 = rnd64();
      step();
      n_checks++; if (out_data !== exp_res) begin n_fail++; $display("FAIL hold_data[%0d]: got %h want %h", i, out_data, exp_res); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid[%0d]: got %b want 1", i, out_valid); end
    end
    // Release with a new request already pending: it must not be taken on the release edge.
    nxt = rnd64();
    mode = 1'b0; key1 = RT_K1; key2 = RT_K2; in_data = nxt; in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_no_accept: got in_ready %b want 1", in_ready); end
    run_op(1'b0, RT_K1, RT_K2, nxt, res, lat, tmo);
    n_checks++; if (lat !== 48) begin n_fail++; $display("FAIL hold_next_latency: got %0d want 48", lat); end
    exp_res = m_tdes(1'b0, RT_K1, RT_K2, nxt);
    n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL hold_next_data: got %h want %h", res, exp_res); end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] res;
    int lat;
    bit tmo;
    mode = 1'b0; key1 = rnd64(); key2 = rnd64(); in_data = rnd64(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (30) step();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_run_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_run_in_ready: got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_run_busy: got %b want 0", busy); end
    n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL rst_run_out_data: got %h want 0", out_data); end
    step();
    step();
    rst = 1'b0;
    run_op(1'b0, KAT_KEY, KAT_KEY, KAT_PT, res, lat, tmo);
    n_checks++; if (lat !== 48) begin n_fail++; $display("FAIL rst_run_latency: got %0d want 48", lat); end
    n_checks++; if (res !== KAT_CT) begin n_fail++; $display("FAIL rst_run_data: got %h want %h", res, KAT_CT); end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [63:0] blk [2];
    logic [63:0] res [2];
    logic [63:0] exp_res;
    int acc_t [2];
    int n_acc = 0, n_res = 0, cyc = 0;
    bit acc;
    blk[0] = rnd64();
    blk[1] = rnd64();
    out_ready = 1'b1;
    mode = 1'b0; key1 = RT_K1; key2 = RT_K2; in_data = blk[0]; in_valid = 1'b1;
    while (n_res < 2 && cyc < 300) begin
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) in_data = blk[1];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        res[n_res] = out_data;
        n_res++;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++; if (n_res !== 2) begin n_fail++; $display("FAIL b2b_results: got %0d want 2", n_res); end
    if (n_acc == 2 && n_res == 2) begin
      n_checks++; if (acc_t[1] - acc_t[0] !== 50) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 50", acc_t[1] - acc_t[0]); end
      for (int i = 0; i < 2; i++) begin
        exp_res = m_tdes(1'b0, RT_K1, RT_K2, blk[i]);
        n_checks++; if (res[i] !== exp_res) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, res[i], exp_res); end
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_kat_encrypt();
    test_kat_decrypt();
    test_round_trip();
    test_done_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
